// File: rtl/lcb_rx_framer_pkg.sv
// Shared types and defaults for the LCB receive framer.
package lcb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } rxState_t;

  localparam int DEF_PKT_LEN    = 24;
  localparam int DEF_GAP_CYCLES = 400;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == ERR_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/lcb_rx_framer_gap_timer.sv
// Inter-byte gap timer: loadable down-counter, expire flags the step that reaches 0.
module lcb_gap_timer #(
  parameter int GAP_CYCLES = 400
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // A load in the same cycle always wins over expiry.
  assign expire = en && !load && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(GAP_CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/lcb_rx_framer.sv
// LCB answer-packet framer: UART bytes -> 32-entry RAM writes, hold/release handshake.
// Optional checksum check on the last byte when LCB_RX_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first byte of a packet
// RECV  | collecting bytes, gap timer running
// HOLD  | packet complete, buffer owned by the read arbiter
module lcb_rx_framer
  import lcb_rx_pkg::*;
#(
  parameter int PKT_LEN    = DEF_PKT_LEN,
  parameter int ADDR_W     = 5,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstTx,
  input  logic              iValid,
  input  logic [7:0]        iData,
  input  logic              rstWr,
  output logic [7:0]        oWrData,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oWE,
  output logic              oDone,
  output logic              oBusy,
  output logic              oErrShort,
  output logic              oErrOverrun,
`ifdef LCB_RX_CHECKSUM_EN
  output logic              oErrCsum,
`endif
  output logic [7:0]        oErrCnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PKT_LEN - 1);

  rxState_t          state, stateNext;
  logic [ADDR_W-1:0] count, countNext;
  logic [ADDR_W-1:0] writeIdx;
  logic              accept;
  logic              weNext;
  logic              doneNext, donePend;
  logic              errShortNext, errOverNext, errCsumNext, errAny;
  logic              timerLoad, timerEn, timerExpire;
  logic              csumOk;

  // Only RECV continues a packet; IDLE and HOLD+rstWr both start at address 0.
  assign writeIdx = (state == RECV) ? count : '0;

  assign timerLoad = accept;
  assign timerEn   = (state == RECV) && !iValid;

  lcb_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) uGapTimer (
    .clk   (clk),
    .rst   (rst),
    .load  (timerLoad),
    .en    (timerEn),
    .expire(timerExpire)
  );

`ifdef LCB_RX_CHECKSUM_EN
  logic [7:0] csumAcc, csumBase;

  assign csumBase = (writeIdx == '0) ? 8'h00 : csumAcc;
  assign csumOk   = (iData == csumBase);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csumAcc  <= 8'h00;
      oErrCsum <= 1'b0;
    end else begin
      oErrCsum <= errCsumNext;
      if (accept) csumAcc <= csumBase ^ iData;
    end
  end
`else
  assign csumOk = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext    = state;
    countNext    = count;
    accept       = 1'b0;
    weNext       = 1'b0;
    doneNext     = 1'b0;
    errShortNext = 1'b0;
    errOverNext  = 1'b0;
    errCsumNext  = 1'b0;

    case (state)
      IDLE: begin
        if (iValid) accept = 1'b1;
      end
      RECV: begin
        // rstTx outranks a byte in the same cycle.
        if (rstTx) begin
          errShortNext = 1'b1;
          stateNext    = IDLE;
          countNext    = '0;
        end else if (iValid) begin
          accept = 1'b1;
        end else if (timerExpire) begin
          errShortNext = 1'b1;
          stateNext    = IDLE;
          countNext    = '0;
        end
      end
      HOLD: begin
        if (rstWr && iValid) begin
          accept = 1'b1;
        end else if (rstWr) begin
          stateNext = IDLE;
        end else if (iValid) begin
          errOverNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase

    if (accept) begin
      weNext = 1'b1;
      if (writeIdx == LAST_IDX) begin
        countNext = '0;
        if (csumOk) begin
          stateNext = HOLD;
          doneNext  = 1'b1;
        end else begin
          stateNext   = IDLE;
          errCsumNext = 1'b1;
        end
      end else begin
        countNext = writeIdx + 1'b1;
        stateNext = RECV;
      end
    end
  end

  assign errAny = errShortNext || errOverNext || errCsumNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oWE         <= 1'b0;
      oWrAddr     <= '0;
      oWrData     <= 8'h00;
      donePend    <= 1'b0;
      oDone       <= 1'b0;
      oBusy       <= 1'b0;
      oErrShort   <= 1'b0;
      oErrOverrun <= 1'b0;
      oErrCnt     <= 8'h00;
    end else begin
      oWE         <= weNext;
      if (weNext) begin
        oWrAddr <= writeIdx;
        oWrData <= iData;
      end
      // Done trails the last write by one cycle so the RAM has the byte first.
      donePend    <= doneNext;
      oDone       <= donePend;
      oBusy       <= (stateNext == HOLD);
      oErrShort   <= errShortNext;
      oErrOverrun <= errOverNext;
      if (errAny) oErrCnt <= satInc(oErrCnt);
    end
  end

endmodule

// File: doc/lcb_rx_framer.md
Name: lcb_rx_framer

Overview:
Packet framer between a channel's UART receiver and its 32-entry byte RAM. Takes the received-byte strobe and data, delimits LCB answer packets by length and inter-byte gap, and generates the RAM write address, data and write enable. When a packet is complete it holds the buffer and signals the read-side arbiter, then releases on that arbiter's release pulse. One instance per LCB channel, all in the 80 MHz domain.

Parameters:
PKT_LEN, 24, bytes per valid LCB answer packet (1..32)
ADDR_W, 5, RAM address width (2**ADDR_W >= PKT_LEN)
GAP_CYCLES, 400, idle clk cycles after the last byte before a partial packet is declared short

Ports:
clk  in  1  80 MHz system clock
rst  in  1  reset, asynchronous, active-low
rstTx  in  1  one-cycle pulse: transmitter issued a new request
iValid  in  1  one-cycle pulse: received byte on iData
iData  in  8  received byte
rstWr  in  1  one-cycle pulse from read arbiter: buffer consumed, release
oWrData  out  8  RAM write data
oWrAddr  out  ADDR_W  RAM write address
oWE  out  1  RAM write enable pulse
oDone  out  1  one-cycle pulse: complete packet in RAM
oBusy  out  1  high while the buffer is held (HOLD)
oErrShort  out  1  pulse: packet aborted, either gap timeout or rstTx mid-packet
oErrOverrun  out  1  pulse: byte arrived while in HOLD and was discarded
oErrCnt  out  8  saturating count of all error pulses

Behaviour:
- Reset, asynchronous on rst low: state IDLE, byte count 0, gap timer 0. All outputs 0, including oErrCnt.
- All outputs are registered. oWE, oWrAddr and oWrData appear 1 cycle after the accepted iValid. oWrAddr equals the byte index (0..PKT_LEN-1).
- IDLE:
  - iValid: write at addr 0, count=1, load timer=GAP_CYCLES, go to RECV.
  - rstTx in IDLE: no effect.
- RECV:
  - iValid: write at addr=count, count+1, reload timer.
  - When count reaches PKT_LEN: go to HOLD. oDone pulses 1 cycle after the last oWE.
  - Otherwise the timer decrements each cycle without iValid. At 0: oErrShort pulse, count=0, go to IDLE; bytes already written are abandoned.
  - iValid in the same cycle the timer would expire: the byte wins, the timer reloads.
  - rstTx in RECV: oErrShort pulse, go to IDLE. A simultaneous iValid is discarded because rstTx has priority.
- HOLD:
  - oBusy=1. No writes occur.
  - iValid alone: oErrOverrun pulse, byte dropped.
  - rstWr: go to IDLE.
  - rstWr together with iValid: the byte is written at addr 0, go to RECV.
  - rstTx is ignored in HOLD.
- oErrCnt increments by 1 per error pulse (short, overrun, checksum) and saturates at 255. At most one error pulse occurs per cycle.
- Count and address never wrap: PKT_LEN bytes always end in HOLD before addr PKT_LEN would be written.

Optional Feature:
LCB_RX_CHECKSUM_EN
- Defined:
  - The last byte is the XOR of bytes 0..PKT_LEN-2, accumulated on accept.
  - Mismatch at byte PKT_LEN: no oDone, oErrCsum pulse, go to IDLE instead of HOLD.
  - Adds port oErrCsum (out, 1); its pulses also count into oErrCnt.
- Undefined: no XOR logic and no oErrCsum port; every length-complete packet gives oDone.

Decomposition:
- Package lcb_rx_pkg:
  - state enum (IDLE, RECV, HOLD)
  - default PKT_LEN/GAP_CYCLES constants
  - error-count saturation value 8'hFF
- One natural sub-module, lcb_gap_timer:
  - loadable down-counter with inputs load and en, output expire; width $clog2(GAP_CYCLES+1).

Test Plan:
1. 24 bytes 0x01..0x18, 170 cycles apart -> 24 oWE with addr 0..23 and matching data; oDone once, 1 cycle after the last oWE; oBusy=1; no errors.
2. 10 bytes then silence -> oErrShort exactly 400 cycles after the 10th accept, oErrCnt=1, no oDone; the next byte is written at addr 0.
3. Full packet, then a byte in HOLD -> oErrOverrun, no oWE, oErrCnt=1. Then rstWr in the same cycle as byte 0xA5 -> oWE addr 0 data 0xA5, state RECV.
4. rstTx after byte 5 -> oErrShort, IDLE. rstTx during HOLD -> no change, oBusy stays 1.
5. rst low mid-packet, 3 cycles after byte 7 -> all outputs 0 immediately, without a clock edge. After release a full packet gives normal oDone. 300 forced overruns -> oErrCnt holds at 255.
6. With LCB_RX_CHECKSUM_EN, last byte correct -> oDone. Last byte XOR 0x01 -> oErrCsum, no oDone, IDLE.
